ir_packet_decoder: RTL and testbench
====================================

Name: ir_packet_decoder

Overview:
- Car-side counterpart of the IR transmitter path: takes the raw modulated IR waveform (carrier bursts) and recovers the 4-bit drive command {FORWARD, BACKWARD, LEFT, RIGHT}.
- Measures each burst's length in carrier pulses, then walks the frame Start -> CarSelect -> Right -> Left -> Backward -> Forward.
- Publishes a validated command with a one-cycle strobe and flags malformed frames.
- Defaults target the yellow car (Start 88, Select 22, Asserted 44, Deasserted 22 pulses) at 50 MHz with a 40 kHz carrier.

Parameters:
- GAP_CYCLES, 2500, clocks with no carrier rising edge that end a burst (2 carrier periods).
- FRAME_TIMEOUT, 5000000, clocks with no carrier rising edge that abort a partial frame (100 ms). Must exceed GAP_CYCLES.
- START_MIN, 80, minimum pulse count classified as Start.
- SELECT_MIN, 18, minimum CarSelect pulse count.
- SELECT_MAX, 26, maximum CarSelect pulse count.
- DEASSERT_MIN, 18, minimum data-burst count (below this is noise/error).
- ASSERT_MIN, 36, data-burst count at or above this (and below START_MIN) decodes as 1.

Ports:
- CLK, input, 1, system clock.
- RESET, input, 1, asynchronous active-low reset.
- IR_IN, input, 1, raw modulated IR waveform, asynchronous to CLK.
- CMD, output, 4, last valid command: [0] right, [1] left, [2] backward, [3] forward.
- CMD_VALID, output, 1, one-cycle strobe when CMD updates.
- FRAME_ERR, output, 1, one-cycle strobe on an aborted or malformed frame.
- BUSY, output, 1, high while a frame is in progress (state not IDLE).

Behaviour:
- Reset (RESET=0, async): CMD=0, CMD_VALID=0, FRAME_ERR=0, BUSY=0. All counters are cleared, the state goes to IDLE, and the synchroniser flops are cleared.
- IR_IN passes through a 2-flop synchroniser. A rising edge is detected on the synchronised signal.
- Pulse counter (8-bit): increments on each rising edge and saturates at 255.
- Gap counter (24-bit): clears on each rising edge, otherwise increments, saturating.
- Burst end: the gap counter reaches exactly GAP_CYCLES while the pulse count is nonzero. The burst is classified with count N that same cycle, and the pulse counter clears.
- FSM states: IDLE, EXP_SELECT, EXP_BITS. A 2-bit bit index selects the data bit.
- IDLE:
  - N >= START_MIN -> EXP_SELECT.
  - Any other N is discarded silently with no FRAME_ERR.
- EXP_SELECT:
  - SELECT_MIN <= N <= SELECT_MAX -> EXP_BITS, index=0.
  - N >= START_MIN -> remain in EXP_SELECT (re-sync); no error.
  - Any other N -> IDLE, FRAME_ERR.
- EXP_BITS:
  - N >= START_MIN -> EXP_SELECT; the partial frame is dropped with no error.
  - ASSERT_MIN <= N < START_MIN -> shift register bit[index]=1.
  - DEASSERT_MIN <= N < ASSERT_MIN -> bit[index]=0.
  - N < DEASSERT_MIN -> IDLE, FRAME_ERR.
  - On the 4th data bit (index=3): next cycle CMD is loaded with the complete 4-bit shift result, CMD_VALID=1, state -> IDLE.
- Frame timeout: in EXP_SELECT or EXP_BITS, the gap counter reaches FRAME_TIMEOUT -> IDLE, FRAME_ERR. The partial frame is discarded and CMD is held.
- Latency: CMD_VALID rises GAP_CYCLES+3 clocks after the final rising edge of the Forward burst at the IR_IN pin (2 sync + GAP_CYCLES + 1 register).
- CMD is held between frames and is never cleared except by reset.
- CMD_VALID and FRAME_ERR are never high in the same cycle.
- A burst end and a frame timeout cannot coincide given FRAME_TIMEOUT > GAP_CYCLES; a burst end takes priority regardless.
- IR_IN stuck high or low: there are no further edges, so any open burst closes after GAP_CYCLES and an open frame times out. No lockup occurs.
- Reset asserted mid-frame: the state returns to IDLE immediately. The next frame after release decodes normally.

Test Plan:
Simulation overrides: GAP_CYCLES=20, FRAME_TIMEOUT=400; the carrier is 10-clock period, 50% duty; gaps between bursts are 60 clocks.
- Frame 88/22/44/22/22/44 pulses -> one CMD_VALID, CMD=4'b1001. The strobe occurs exactly 23 clocks after the last rising edge; FRAME_ERR stays 0.
- Back-to-back frames giving 4'b0110 then 4'b0000 -> two strobes. CMD holds 0110 until the second strobe.
- Start, Select, then 2 data bursts, then silence -> FRAME_ERR pulses once at 400 clocks after the last edge. BUSY drops and CMD is unchanged.
- Start, then a 10-pulse burst -> FRAME_ERR, state IDLE. A following valid frame 88/22/44/44/44/44 -> CMD=4'b1111.
- Isolated 5-pulse noise bursts in IDLE -> no strobes and BUSY stays 0. A Start burst in the middle of the data bits, followed by a full frame -> exactly one CMD_VALID with the new frame's value.
- RESET low for 3 cycles during the 2nd data burst -> all outputs go to 0 asynchronously. The next full frame decodes correctly.

Source files
------------

// File: rtl/ir_packet_decoder.sv
// IR frame decoder: counts carrier pulses per burst and walks the frame
// Start -> CarSelect -> Right -> Left -> Backward -> Forward into a 4-bit drive command.
module ir_packet_decoder #(
  parameter int GAP_CYCLES    = 2500,
  parameter int FRAME_TIMEOUT = 5000000,
  parameter int START_MIN     = 80,
  parameter int SELECT_MIN    = 18,
  parameter int SELECT_MAX    = 26,
  parameter int DEASSERT_MIN  = 18,
  parameter int ASSERT_MIN    = 36
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IR_IN,
  output logic [3:0] CMD,
  output logic       CMD_VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam logic [23:0] GAP_C = 24'(GAP_CYCLES);
  localparam logic [23:0] TO_C  = 24'(FRAME_TIMEOUT);
  localparam logic [7:0]  START_N = 8'(START_MIN);
  localparam logic [7:0]  SELLO_N = 8'(SELECT_MIN);
  localparam logic [7:0]  SELHI_N = 8'(SELECT_MAX);
  localparam logic [7:0]  DEAS_N  = 8'(DEASSERT_MIN);
  localparam logic [7:0]  ASRT_N  = 8'(ASSERT_MIN);

  typedef enum logic [1:0] {IDLE, EXP_SELECT, EXP_BITS} state_t;

  state_t      state, state_nxt;
  logic [2:0]  sync;       // [1:0] synchroniser, [2] delayed copy for edge detect
  logic        rise;
  logic [7:0]  pulse_cnt;
  logic [23:0] gap_cnt;
  logic        burst_end, timeout;
  logic [1:0]  idx, idx_nxt;
  logic [3:0]  shift, shift_nxt;
  logic        cmd_load, err;

  assign rise      = sync[1] & ~sync[2];
  assign burst_end = (gap_cnt == GAP_C) && (pulse_cnt != 8'd0);
  assign timeout   = (gap_cnt == TO_C) && (state != IDLE) && !burst_end;
  assign BUSY      = (state != IDLE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync      <= '0;
      pulse_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      sync <= {sync[1:0], IR_IN};
      // A new edge landing on the closing cycle starts the next burst at 1
      if (burst_end)
        pulse_cnt <= rise ? 8'd1 : 8'd0;
      else if (rise && pulse_cnt != 8'hff)
        pulse_cnt <= pulse_cnt + 8'd1;
      if (rise)
        gap_cnt <= '0;
      else if (gap_cnt != 24'hffffff)
        gap_cnt <= gap_cnt + 24'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    shift_nxt = shift;
    cmd_load  = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (burst_end && pulse_cnt >= START_N) state_nxt = EXP_SELECT;
      end
      EXP_SELECT: begin
        if (burst_end) begin
          if (pulse_cnt >= SELLO_N && pulse_cnt <= SELHI_N) begin
            state_nxt = EXP_BITS;
            idx_nxt   = 2'd0;
          end else if (pulse_cnt < START_N) begin
            state_nxt = IDLE;
            err       = 1'b1;
          end
        end else if (timeout) begin
          state_nxt = IDLE;
          err       = 1'b1;
        end
      end
      EXP_BITS: begin
        if (burst_end) begin
          if (pulse_cnt >= START_N) begin
            state_nxt = EXP_SELECT;
          end else if (pulse_cnt < DEAS_N) begin
            state_nxt = IDLE;
            err       = 1'b1;
          end else begin
            shift_nxt[idx] = (pulse_cnt >= ASRT_N);
            if (idx == 2'd3) begin
              cmd_load  = 1'b1;
              state_nxt = IDLE;
            end else begin
              idx_nxt = idx + 2'd1;
            end
          end
        end else if (timeout) begin
          state_nxt = IDLE;
          err       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      idx       <= '0;
      shift     <= '0;
      CMD       <= '0;
      CMD_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      shift     <= shift_nxt;
      if (cmd_load) CMD <= shift_nxt;
      CMD_VALID <= cmd_load;
      FRAME_ERR <= err;
    end
  end

endmodule

// File: tb/tb_ir_packet_decoder.sv
// Directed + randomized bench for ir_packet_decoder against a burst-level frame model.
module tb_ir_packet_decoder;
  localparam int GAP = 20;
  localparam int TO  = 400;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       IR_IN = 1'b0;
  logic [3:0] CMD;
  logic       CMD_VALID, FRAME_ERR, BUSY;

  ir_packet_decoder #(.GAP_CYCLES(GAP), .FRAME_TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .IR_IN(IR_IN),
    .CMD(CMD), .CMD_VALID(CMD_VALID), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // strobe monitor
  int   n_valid = 0, n_err = 0, valid_cyc = 0, err_cyc = 0;
  logic both_hi = 1'b0;
  always @(negedge CLK) begin
    if (CMD_VALID) begin n_valid++; valid_cyc = cyc; end
    if (FRAME_ERR) begin n_err++; err_cyc = cyc; end
    if (CMD_VALID && FRAME_ERR) both_hi = 1'b1;
  end

  int n_chk = 0, n_pass = 0;
  int last_rise = 0;

  // frame model: 0 idle, 1 awaiting select, 2 collecting data bits
  int         mstate = 0, idx = 0, exp_valid = 0, exp_err = 0;
  logic [3:0] bits = '0, exp_cmd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge CLK); #1; end
  endtask

  task automatic mdl_burst(input int n);
    case (mstate)
      0: if (n >= 80) mstate = 1;
      1: if (n >= 18 && n <= 26) begin mstate = 2; idx = 0; end
         else if (n < 80) begin mstate = 0; exp_err++; end
      default:
        if (n >= 80) mstate = 1;
        else if (n < 18) begin mstate = 0; exp_err++; end
        else begin
          bits[idx] = (n >= 36);
          if (idx == 3) begin exp_cmd = bits; exp_valid++; mstate = 0; end
          else idx++;
        end
    endcase
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, n_valid, exp_valid);
    chk({tag, ".err"}, n_err, exp_err);
    chk({tag, ".cmd"}, {28'd0, CMD}, {28'd0, exp_cmd});
    chk({tag, ".busy"}, {31'd0, BUSY}, {31'd0, mstate != 0});
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      IR_IN = 1'b1; last_rise = cyc; tick(5);
      IR_IN = 1'b0; tick(5);
    end
  endtask

  // n pulses followed by a 60-clock quiet gap, then compare against the model
  task automatic burst(input int n, input string tag);
    pulses(n);
    tick(55);
    mdl_burst(n);
    check_state(tag);
  endtask

  task automatic frame(input int s, input int sel, input int b0, input int b1,
                       input int b2, input int b3, input string tag);
    burst(s, tag); burst(sel, tag); burst(b0, tag);
    burst(b1, tag); burst(b2, tag); burst(b3, tag);
  endtask

  function automatic int rnd_data();
    int r;
    r = $urandom_range(0, 11);
    if (r == 0) return $urandom_range(5, 17);
    if (r == 1) return $urandom_range(80, 90);
    return $urandom_range(18, 60);
  endfunction

  initial begin
    tick(3);
    chk("rst.cmd", {28'd0, CMD}, 32'd0);
    chk("rst.valid", {31'd0, CMD_VALID}, 32'd0);
    chk("rst.err", {31'd0, FRAME_ERR}, 32'd0);
    chk("rst.busy", {31'd0, BUSY}, 32'd0);
    RESET = 1'b1;
    tick(5);

    // basic frame; rise driven after edge P, first sampled at P+1, strobe GAP+3 later
    frame(88, 22, 44, 22, 22, 44, "f1001");
    chk("f1001.value", {28'd0, CMD}, 32'h9);
    chk("f1001.latency", valid_cyc - last_rise, GAP + 4);

    frame(88, 22, 22, 44, 44, 22, "f0110");
    frame(88, 22, 22, 22, 22, 22, "f0000");
    chk("f0000.value", {28'd0, CMD}, 32'h0);

    // partial frame then silence -> timeout
    burst(88, "to"); burst(22, "to"); burst(44, "to"); burst(44, "to");
    tick(TO + 50 - 60);
    if (mstate != 0) begin mstate = 0; exp_err++; end
    check_state("to");
    chk("to.latency", err_cyc - last_rise, TO + 4);

    burst(88, "short"); burst(10, "short");
    frame(88, 22, 44, 44, 44, 44, "f1111");

    burst(5, "noise"); burst(5, "noise"); burst(5, "noise");
    burst(88, "resync"); burst(22, "resync"); burst(44, "resync"); burst(22, "resync");
    frame(88, 22, 44, 44, 22, 22, "f0011");

    // classification boundaries
    frame(80, 18, 36, 35, 79, 18, "bound");
    chk("bound.value", {28'd0, CMD}, 32'h5);
    burst(80, "sel27"); burst(27, "sel27");
    burst(80, "sel17"); burst(17, "sel17");
    burst(80, "bit17"); burst(26, "bit17"); burst(17, "bit17");

    // reset during the second data burst
    burst(88, "rst"); burst(22, "rst"); burst(44, "rst");
    pulses(10);
    RESET = 1'b0; #1;
    chk("amid.cmd", {28'd0, CMD}, 32'd0);
    chk("amid.valid", {31'd0, CMD_VALID}, 32'd0);
    chk("amid.err", {31'd0, FRAME_ERR}, 32'd0);
    chk("amid.busy", {31'd0, BUSY}, 32'd0);
    tick(3);
    RESET = 1'b1;
    mstate = 0; exp_cmd = '0;
    burst(20, "post");
    frame(88, 22, 22, 44, 22, 44, "f1010");

    for (int f = 0; f < 6; f++) begin
      int sel;
      sel = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 17)) : int'($urandom_range(18, 26));
      frame($urandom_range(80, 95), sel, rnd_data(), rnd_data(), rnd_data(), rnd_data(), "rand");
    end
    tick(TO + 20);
    if (mstate != 0) begin mstate = 0; exp_err++; end
    check_state("rand.end");

    chk("exclusive", {31'd0, both_hi}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
